// File: rtl/mem_ctrl.sv
// Line-oriented memory model on a shared tristate A2/D2/C2 bus. It serves one
// READ_LINE or WRITE_LINE at a time and answers after a fixed latency.
module mem_ctrl #(
    parameter int ADDR2_BUS_SIZE  = 15,
    parameter int DATA2_BUS_SIZE  = 16,
    parameter int CACHE_LINE_SIZE = 16,
    parameter int MEM_DELAY       = 100
) (
    input  logic                      CLK,
    input  logic                      RESET,
    inout  wire  [ADDR2_BUS_SIZE-1:0] A2_WIRE,
    inout  wire  [DATA2_BUS_SIZE-1:0] D2_WIRE,
    inout  wire  [1:0]                C2_WIRE,
    output logic [2:0]                o_dbg_state
);
    localparam int BEATS  = CACHE_LINE_SIZE * 8 / DATA2_BUS_SIZE;
    localparam int LINE_W = CACHE_LINE_SIZE * 8;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(MEM_DELAY + BEATS + 2);
    localparam int LINES  = 2 ** ADDR2_BUS_SIZE;

    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_RESPONSE   = 2'd1;
    localparam logic [1:0] C2_READ_LINE  = 2'd2;
    localparam logic [1:0] C2_WRITE_LINE = 2'd3;

    // The response must not start before the last write beat has been taken.
    if (MEM_DELAY < BEATS + 1) begin : g_bad_delay
        $error("mem_ctrl: MEM_DELAY must be at least BEATS+1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_RECV = 3'd1,
        WR_WAIT = 3'd2,
        RD_WAIT = 3'd3,
        RD_SEND = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [CNT_W-1:0]          r_cnt;
    logic [BEAT_W-1:0]         r_beat;
    logic [ADDR2_BUS_SIZE-1:0] r_addr;
    logic [LINE_W-1:0]         r_mem [LINES];

    logic                      w_cmd_rd;
    logic                      w_cmd_wr;
    logic                      w_accept;
    logic                      w_wr_en;
    logic                      w_c2_en;
    logic                      w_d2_en;
    logic [1:0]                w_c2_val;
    logic [BEAT_W-1:0]         w_wr_beat;
    logic [ADDR2_BUS_SIZE-1:0] w_wr_addr;
    logic [DATA2_BUS_SIZE-1:0] w_rd_beat;

    assign w_cmd_rd = (C2_WIRE == C2_READ_LINE);
    assign w_cmd_wr = (C2_WIRE == C2_WRITE_LINE);
    assign w_accept = (r_state == IDLE) && (w_cmd_rd || w_cmd_wr);

    always_comb begin
        w_next    = r_state;
        w_c2_en   = 1'b0;
        w_c2_val  = C2_NOP;
        w_d2_en   = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_beat = r_beat;
        w_wr_addr = r_addr;
        case (r_state)
            IDLE: begin
                // Beat 0 of a write rides on the same edge as the command.
                w_wr_addr = A2_WIRE;
                w_wr_beat = '0;
                if (w_cmd_wr) begin
                    w_next  = WR_RECV;
                    w_wr_en = 1'b1;
                end else if (w_cmd_rd) begin
                    w_next = RD_WAIT;
                end
            end
            WR_RECV: begin
                if (r_cnt == CNT_W'(BEATS)) w_next = WR_WAIT;
                else w_wr_en = 1'b1;
            end
            WR_WAIT: begin
                w_c2_en = 1'b1;
                if (r_cnt == CNT_W'(MEM_DELAY)) w_next = RESP;
            end
            RESP: begin
                w_c2_en  = 1'b1;
                w_c2_val = C2_RESPONSE;
                w_next   = IDLE;
            end
            RD_WAIT: begin
                w_c2_en = 1'b1;
                if (r_cnt == CNT_W'(MEM_DELAY)) w_next = RD_SEND;
            end
            RD_SEND: begin
                w_c2_en  = 1'b1;
                w_c2_val = C2_RESPONSE;
                w_d2_en  = 1'b1;
                if (r_beat == BEAT_W'(BEATS - 1)) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // r_cnt holds the number of the next edge, counted from the command edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_cnt  <= w_accept ? CNT_W'(1) : '0;
                r_beat <= BEAT_W'(1);
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_beat <= (r_state == RD_WAIT) ? '0 : r_beat + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && w_accept) r_addr <= A2_WIRE;
    end

    // Storage survives reset; only the write strobe is blocked by it.
    always_ff @(posedge CLK) begin
        if (!RESET && w_wr_en)
            r_mem[w_wr_addr][w_wr_beat*DATA2_BUS_SIZE +: DATA2_BUS_SIZE] <= D2_WIRE;
    end

    assign w_rd_beat   = r_mem[r_addr][r_beat*DATA2_BUS_SIZE +: DATA2_BUS_SIZE];
    assign D2_WIRE     = w_d2_en ? w_rd_beat : 'z;
    assign C2_WIRE     = w_c2_en ? w_c2_val : 'z;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: table of line writes/reads plus hand-built sequences for
// a command during a busy read, reset mid-write and an idle bus.
`timescale 1ns/1ps
module tb_mem_ctrl;
    localparam int AW    = 15;
    localparam int DW    = 16;
    localparam int LW    = 128;
    localparam int BEATS = 8;
    localparam int MD    = 100;

    localparam logic [1:0]    NOP      = 2'd0;
    localparam logic [1:0]    RSP      = 2'd1;
    localparam logic [1:0]    RD       = 2'd2;
    localparam logic [1:0]    WR       = 2'd3;
    // Both buses are pulled high, so a released bus reads as all ones.
    localparam logic [1:0]    C2_FLOAT = 2'b11;
    localparam logic [DW-1:0] D2_FLOAT = 16'hFFFF;
    localparam logic [2:0]    ST_IDLE  = 3'd0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] a2_drv = '0;
    logic [DW-1:0] d2_drv = '0;
    logic          d2_en = 1'b0;
    logic [1:0]    c2_drv = NOP;
    logic          c2_en = 1'b0;
    logic [2:0]    dbg_state;

    wire [AW-1:0] a2_wire;
    tri1 [DW-1:0] d2_wire;
    tri1 [1:0]    c2_wire;

    assign a2_wire = a2_drv;
    assign d2_wire = d2_en ? d2_drv : 'z;
    assign c2_wire = c2_en ? c2_drv : 'z;

    mem_ctrl dut (
        .CLK        (clk),
        .RESET      (rst),
        .A2_WIRE    (a2_wire),
        .D2_WIRE    (d2_wire),
        .C2_WIRE    (c2_wire),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
    } vec_t;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        c2_en = 1'b1;
        c2_drv = NOP;
        d2_en = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] line, input string tag);
        int bad_z;
        int bad_nop;
        bad_z = 0;
        bad_nop = 0;
        c2_en = 1'b1; c2_drv = WR; a2_drv = addr;
        d2_en = 1'b1; d2_drv = line[0 +: DW];
        @(posedge clk);
        for (int k = 1; k < BEATS; k++) begin
            @(negedge clk);
            c2_en = 1'b0;
            a2_drv = AW'($urandom);
            d2_drv = line[k*DW +: DW];
            #1;
            if (c2_wire !== C2_FLOAT) bad_z++;
            @(posedge clk);
        end
        @(negedge clk);
        d2_en = 1'b0;
        #1;
        if (c2_wire !== C2_FLOAT || d2_wire !== D2_FLOAT) bad_z++;
        for (int e = BEATS; e < MD; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (c2_wire !== NOP || d2_wire !== D2_FLOAT) bad_nop++;
        end
        check({tag, " wr_recv_released"}, LW'(bad_z), '0);
        check({tag, " wr_wait_nop"}, LW'(bad_nop), '0);
        @(posedge clk);
        @(negedge clk);
        check({tag, " wr_response_c2"}, LW'(c2_wire), LW'(RSP));
        check({tag, " wr_response_d2"}, LW'(d2_wire), LW'(D2_FLOAT));
        @(posedge clk);
        @(negedge clk);
        check({tag, " wr_release_c2"}, LW'(c2_wire), LW'(C2_FLOAT));
        check({tag, " wr_done_idle"}, LW'(dbg_state), LW'(ST_IDLE));
        idle_bus();
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] exp_line,
                           input int inject_at, input string tag);
        int bad_nop;
        logic [DW-1:0] exp_beat;
        bad_nop = 0;
        for (int k = 0; k < BEATS; k++) exp_q.push_back(exp_line[k*DW +: DW]);
        c2_en = 1'b1; c2_drv = RD; a2_drv = addr; d2_en = 1'b0;
        @(posedge clk);
        for (int e = 0; e < MD; e++) begin
            @(negedge clk);
            if (e == 0) begin
                c2_en = 1'b0;
                a2_drv = AW'($urandom);
            end
            if (inject_at > 0 && e == inject_at) begin
                c2_en = 1'b0;
                d2_en = 1'b0;
            end
            #1;
            if (!(inject_at > 0 && e == inject_at)) begin
                if (c2_wire !== NOP || d2_wire !== D2_FLOAT) bad_nop++;
            end
            // A write command while the read owns the bus must be ignored.
            if (inject_at > 0 && e == inject_at - 1) begin
                c2_en = 1'b1; c2_drv = WR; a2_drv = addr;
                d2_en = 1'b1; d2_drv = 16'h5A5A;
            end
            @(posedge clk);
        end
        check({tag, " rd_wait_nop"}, LW'(bad_nop), '0);
        for (int k = 0; k < BEATS; k++) begin
            @(negedge clk);
            check($sformatf("%s rd_beat%0d_c2", tag, k), LW'(c2_wire), LW'(RSP));
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s rd_beat%0d: got beat %0h, expected queue empty", tag, k, d2_wire);
            end else begin
                exp_beat = exp_q.pop_front();
                check($sformatf("%s rd_beat%0d_d2", tag, k), LW'(d2_wire), LW'(exp_beat));
            end
            @(posedge clk);
        end
        @(negedge clk);
        check({tag, " rd_release_c2"}, LW'(c2_wire), LW'(C2_FLOAT));
        check({tag, " rd_release_d2"}, LW'(d2_wire), LW'(D2_FLOAT));
        check({tag, " rd_done_idle"}, LW'(dbg_state), LW'(ST_IDLE));
        idle_bus();
    endtask

    task automatic do_write_abort(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                                  input int reset_edge);
        c2_en = 1'b1; c2_drv = WR; a2_drv = addr;
        d2_en = 1'b1; d2_drv = line[0 +: DW];
        @(posedge clk);
        for (int k = 1; k < reset_edge; k++) begin
            @(negedge clk);
            c2_en = 1'b0;
            d2_drv = line[k*DW +: DW];
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        d2_drv = line[reset_edge*DW +: DW];
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        d2_en = 1'b0;
        #1;
        check("abort_c2_released", LW'(c2_wire), LW'(C2_FLOAT));
        check("abort_d2_released", LW'(d2_wire), LW'(D2_FLOAT));
        check("abort_idle", LW'(dbg_state), LW'(ST_IDLE));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[7];
        logic [LW-1:0] l1, p2, p3, l55, laa, mixed;
        int            bad;

        for (int i = 0; i < 16; i++) l1[i*8 +: 8] = 8'(i);
        for (int i = 0; i < LW / 32; i++) begin
            p2[i*32 +: 32] = $urandom;
            p3[i*32 +: 32] = ~p2[i*32 +: 32] ^ 32'h0F0F_F0F0;
        end
        l55   = {16{8'h55}};
        laa   = {16{8'hAA}};
        mixed = {{8{8'h55}}, {8{8'hAA}}};
        vecs[0] = '{wr: 1'b1, addr: 15'h1234, line: l1};
        vecs[1] = '{wr: 1'b0, addr: 15'h1234, line: l1};
        vecs[2] = '{wr: 1'b1, addr: 15'h7FFF, line: p2};
        vecs[3] = '{wr: 1'b1, addr: 15'h0000, line: p3};
        vecs[4] = '{wr: 1'b0, addr: 15'h7FFF, line: p2};
        vecs[5] = '{wr: 1'b0, addr: 15'h0000, line: p3};
        vecs[6] = '{wr: 1'b1, addr: 15'h0010, line: l55};

        // Reset with a released C2 (reads as WRITE_LINE): reset must win.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_c2_released", LW'(c2_wire), LW'(C2_FLOAT));
        check("reset_d2_released", LW'(d2_wire), LW'(D2_FLOAT));
        check("reset_idle", LW'(dbg_state), LW'(ST_IDLE));
        rst = 1'b0;
        idle_bus();
        @(posedge clk);
        @(negedge clk);
        check("post_reset_idle", LW'(dbg_state), LW'(ST_IDLE));

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].line, $sformatf("v%0d", i));
            else do_read(vecs[i].addr, vecs[i].line, 0, $sformatf("v%0d", i));
        end

        do_read(15'h1234, l1, 50, "busy_cmd");
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (dbg_state !== ST_IDLE || d2_wire !== D2_FLOAT) bad++;
        end
        check("busy_cmd_no_extra_txn", LW'(bad), '0);

        do_write_abort(15'h0010, laa, 4);
        do_read(15'h0010, mixed, 0, "abort_read");

        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            c2_drv = ($urandom_range(0, 1) == 0) ? NOP : RSP;
            a2_drv = AW'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (dbg_state !== ST_IDLE || d2_wire !== D2_FLOAT) bad++;
        end
        check("idle_ignores_nop_rsp", LW'(bad), '0);
        check("scoreboard_drained", LW'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
